// File: rtl/video_timing_pkg.sv
// Shared register map, reset defaults and the per-slot timing record for
// the raster timing generator.
package video_timing_pkg;

  localparam int VT_FW = 16;

  localparam logic [3:0] VT_HPERIOD = 4'd0;
  localparam logic [3:0] VT_HS_BEG  = 4'd1;
  localparam logic [3:0] VT_HS_END  = 4'd2;
  localparam logic [3:0] VT_HA_BEG  = 4'd3;
  localparam logic [3:0] VT_HA_END  = 4'd4;
  localparam logic [3:0] VT_VPERIOD = 4'd5;
  localparam logic [3:0] VT_VS_BEG  = 4'd6;
  localparam logic [3:0] VT_VS_END  = 4'd7;
  localparam logic [3:0] VT_VA_BEG  = 4'd8;
  localparam logic [3:0] VT_VA_END  = 4'd9;

  // Fields are stored at a fixed width; each slot masks them to HW/VW.
  typedef struct packed {
    logic [VT_FW-1:0] hperiod, hs_beg, hs_end, ha_beg, ha_end;
    logic [VT_FW-1:0] vperiod, vs_beg, vs_end, va_beg, va_end;
  } vt_mode_t;

  localparam vt_mode_t VT_MODE_DEFAULT = '{
    hperiod: 16'd448, hs_beg: 16'd11, hs_end: 16'd43, ha_beg: 16'd88, ha_end: 16'd448,
    vperiod: 16'd320, vs_beg: 16'd8,  vs_end: 16'd11, va_beg: 16'd32, va_end: 16'd320
  };

  // Half-open window [beg,fin); beg >= fin yields an empty window.
  function automatic logic in_window(input logic [VT_FW-1:0] pos,
                                     input logic [VT_FW-1:0] beg,
                                     input logic [VT_FW-1:0] fin);
    return (pos >= beg) && (pos < fin);
  endfunction

endpackage

// File: rtl/video_timing_regs.sv
// Timing-mode register bank with write port and frame-boundary shadow copy.
module video_timing_regs
  import video_timing_pkg::*;
#(
  parameter int HW     = 10,
  parameter int VW     = 10,
  parameter int NMODES = 4,
  parameter int MW     = 2,
  parameter int CW     = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_we_i,
  input  logic [MW-1:0] cfg_mode_i,
  input  logic [3:0]    cfg_addr_i,
  input  logic [CW-1:0] cfg_wdata_i,
  input  logic          load_i,
  input  logic [MW-1:0] sel_i,
  output vt_mode_t      shadow_o,
  output vt_mode_t      shadow_nxt_o,
  output logic [MW-1:0] mode_active_o
);

  localparam int NSLOT = 1 << MW;
  localparam logic [VT_FW-1:0] HMASK = VT_FW'((32'd1 << HW) - 32'd1);
  localparam logic [VT_FW-1:0] VMASK = VT_FW'((32'd1 << VW) - 32'd1);
  localparam logic [NSLOT-1:0] MODE_OK = NSLOT'((64'd1 << NMODES) - 64'd1);

  function automatic vt_mode_t trunc_mode(input vt_mode_t m);
    vt_mode_t r;
    r.hperiod = m.hperiod & HMASK;  r.hs_beg = m.hs_beg & HMASK;
    r.hs_end  = m.hs_end  & HMASK;  r.ha_beg = m.ha_beg & HMASK;
    r.ha_end  = m.ha_end  & HMASK;
    r.vperiod = m.vperiod & VMASK;  r.vs_beg = m.vs_beg & VMASK;
    r.vs_end  = m.vs_end  & VMASK;  r.va_beg = m.va_beg & VMASK;
    r.va_end  = m.va_end  & VMASK;
    return r;
  endfunction

  function automatic vt_mode_t write_field(input vt_mode_t m, input logic [3:0] a,
                                           input logic [VT_FW-1:0] d);
    vt_mode_t r;
    r = m;
    case (a)
      VT_HPERIOD: r.hperiod = d & HMASK;
      VT_HS_BEG:  r.hs_beg  = d & HMASK;
      VT_HS_END:  r.hs_end  = d & HMASK;
      VT_HA_BEG:  r.ha_beg  = d & HMASK;
      VT_HA_END:  r.ha_end  = d & HMASK;
      VT_VPERIOD: r.vperiod = d & VMASK;
      VT_VS_BEG:  r.vs_beg  = d & VMASK;
      VT_VS_END:  r.vs_end  = d & VMASK;
      VT_VA_BEG:  r.va_beg  = d & VMASK;
      VT_VA_END:  r.va_end  = d & VMASK;
      default:    r = m;
    endcase
    return r;
  endfunction

  localparam vt_mode_t RST_MODE = trunc_mode(VT_MODE_DEFAULT);

  vt_mode_t      bank_q [NMODES];
  vt_mode_t      bank_d [NMODES];
  vt_mode_t      shadow_q, shadow_d;
  logic [MW-1:0] mode_q, mode_d;

  // The shadow copies from the post-write bank, so a same-cycle write wins.
  always_comb begin
    bank_d   = bank_q;
    shadow_d = shadow_q;
    mode_d   = mode_q;
    if (cfg_we_i && MODE_OK[cfg_mode_i]) begin
      bank_d[cfg_mode_i] = write_field(bank_q[cfg_mode_i], cfg_addr_i, VT_FW'(cfg_wdata_i));
    end
    if (load_i && MODE_OK[sel_i]) begin
      shadow_d = bank_d[sel_i];
      mode_d   = sel_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NMODES; i++) bank_q[i] <= RST_MODE;
      shadow_q <= RST_MODE;
      mode_q   <= '0;
    end else begin
      bank_q   <= bank_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
    end
  end

  assign shadow_o      = shadow_q;
  assign shadow_nxt_o  = shadow_d;
  assign mode_active_o = mode_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, sync/blank/DE decode,
// active-area coordinates and sticky raster interrupts from a shadowed mode.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int HW     = 10,
  parameter int VW     = 10,
  parameter int NMODES = 4,
  parameter int NIRQ   = 2,
  localparam int MW    = (NMODES > 1) ? $clog2(NMODES) : 1,
  localparam int CW    = (HW > VW) ? HW : VW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_ce,
  input  logic [MW-1:0]      mode_sel,
  input  logic               sync_pol,
  input  logic               cfg_we,
  input  logic [MW-1:0]      cfg_mode,
  input  logic [3:0]         cfg_addr,
  input  logic [CW-1:0]      cfg_wdata,
  input  logic [NIRQ*VW-1:0] irq_line,
  input  logic [NIRQ*HW-1:0] irq_col,
  input  logic [NIRQ-1:0]    irq_en,
  input  logic [NIRQ-1:0]    irq_ack,
  output logic [HW-1:0]      hcount,
  output logic [VW-1:0]      vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               csync,
  output logic               hblank,
  output logic               vblank,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [HW-1:0]      act_x,
  output logic [VW-1:0]      act_y,
  output logic [NIRQ-1:0]    irq_pend,
  output logic [7:0]         frame_cnt,
  output logic [MW-1:0]      mode_active
);

  vt_mode_t cur, nxt;
  logic     frame_start_d, line_start_d;
  logic     unused_shadow;

  video_timing_regs #(
    .HW(HW), .VW(VW), .NMODES(NMODES), .MW(MW), .CW(CW)
  ) u_regs (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cfg_we_i      (cfg_we),
    .cfg_mode_i    (cfg_mode),
    .cfg_addr_i    (cfg_addr),
    .cfg_wdata_i   (cfg_wdata),
    .load_i        (frame_start_d),
    .sel_i         (mode_sel),
    .shadow_o      (cur),
    .shadow_nxt_o  (nxt),
    .mode_active_o (mode_active)
  );

  assign unused_shadow = ^{cur, nxt};

  logic [HW-1:0]   hcount_q, hcount_d, hlast, act_x_q, act_x_d;
  logic [VW-1:0]   vcount_q, vcount_d, vlast, act_y_q, act_y_d;
  logic            hwrap, vwrap;
  logic            hs_q, hs_d, vs_q, vs_d, csync_q, csync_d;
  logic            hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
  logic            line_start_q, frame_start_q;
  logic [NIRQ-1:0] irq_pend_q, irq_pend_d, irq_set;
  logic [7:0]      frame_cnt_q, frame_cnt_d;

  // Wrap compares use the frame currently running; periods below 2 clamp to 2.
  always_comb begin
    hlast = (cur.hperiod[HW-1:0] < HW'(2)) ? HW'(1) : cur.hperiod[HW-1:0] - HW'(1);
    vlast = (cur.vperiod[VW-1:0] < VW'(2)) ? VW'(1) : cur.vperiod[VW-1:0] - VW'(1);
    hwrap = hcount_q >= hlast;
    vwrap = vcount_q >= vlast;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_ce) begin
      if (hwrap) begin
        hcount_d     = '0;
        line_start_d = 1'b1;
        if (vwrap) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + VW'(1);
        end
      end else begin
        hcount_d = hcount_q + HW'(1);
      end
    end
    frame_cnt_d = frame_cnt_q + {7'd0, frame_start_d};
  end

  // Decode the new position against the mode that will be in effect after this edge.
  always_comb begin
    hs_d     = in_window(VT_FW'(hcount_d), nxt.hs_beg, nxt.hs_end);
    vs_d     = in_window(VT_FW'(vcount_d), nxt.vs_beg, nxt.vs_end);
    hblank_d = !in_window(VT_FW'(hcount_d), nxt.ha_beg, nxt.ha_end);
    vblank_d = !in_window(VT_FW'(vcount_d), nxt.va_beg, nxt.va_end);
    de_d     = !hblank_d && !vblank_d;
    csync_d  = ~(hs_d ^ vs_d);
    act_x_d  = de_d ? hcount_d - nxt.ha_beg[HW-1:0] : '0;
    act_y_d  = de_d ? vcount_d - nxt.va_beg[VW-1:0] : '0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      irq_set[i] = pix_ce && irq_en[i] &&
                   (hcount_d == irq_col[i*HW +: HW]) && (vcount_d == irq_line[i*VW +: VW]);
    end
    irq_pend_d = irq_set | (irq_pend_q & ~irq_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      csync_q       <= 1'b1;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      de_q          <= 1'b0;
      act_x_q       <= '0;
      act_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      irq_pend_q    <= '0;
      frame_cnt_q   <= '0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      irq_pend_q    <= irq_pend_d;
      frame_cnt_q   <= frame_cnt_d;
      if (pix_ce) begin
        hcount_q <= hcount_d;
        vcount_q <= vcount_d;
        hs_q     <= hs_d;
        vs_q     <= vs_d;
        csync_q  <= csync_d;
        hblank_q <= hblank_d;
        vblank_q <= vblank_d;
        de_q     <= de_d;
        act_x_q  <= act_x_d;
        act_y_q  <= act_y_d;
      end
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = sync_pol ^ hs_q;
  assign vsync       = sync_pol ^ vs_q;
  assign csync       = csync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign act_x       = act_x_q;
  assign act_y       = act_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign irq_pend    = irq_pend_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: stimulus pushes expected outputs per clock edge, a monitor
// pops and compares them one step after each rising edge.
module tb_video_timing_gen;

  // VW = 8 shortens the default frame (vperiod 320 truncates to 64) to 448x64.
  localparam int HW = 10;
  localparam int VW = 8;
  localparam int NM = 4;
  localparam int NI = 2;

  logic             clk = 1'b0, rst_n = 1'b0, pix_ce = 1'b0, sync_pol = 1'b0, cfg_we = 1'b0;
  logic [1:0]       mode_sel = '0, cfg_mode = '0;
  logic [3:0]       cfg_addr = '0;
  logic [9:0]       cfg_wdata = '0;
  logic [NI*VW-1:0] irq_line = '0;
  logic [NI*HW-1:0] irq_col = '0;
  logic [NI-1:0]    irq_en = '0, irq_ack = '0;
  logic [HW-1:0]    hcount, act_x;
  logic [VW-1:0]    vcount, act_y;
  logic             hsync, vsync, csync, hblank, vblank, de, line_start, frame_start;
  logic [NI-1:0]    irq_pend;
  logic [7:0]       frame_cnt;
  logic [1:0]       mode_active;

  video_timing_gen #(.HW(HW), .VW(VW), .NMODES(NM), .NIRQ(NI)) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .mode_sel(mode_sel), .sync_pol(sync_pol),
    .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .irq_line(irq_line), .irq_col(irq_col), .irq_en(irq_en), .irq_ack(irq_ack),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync), .csync(csync),
    .hblank(hblank), .vblank(vblank), .de(de), .line_start(line_start),
    .frame_start(frame_start), .act_x(act_x), .act_y(act_y), .irq_pend(irq_pend),
    .frame_cnt(frame_cnt), .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int h, v;
    bit hsy, vsy, csy, hb, vb, de, ls, fs;
    int ax, ay, pend, fc, mode;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc < cyc) begin
          checks++; errors++;
          $display("FAIL stale_expect cycle %0d: got cycle %0d expected %0d", cyc, cyc, e.cyc);
        end else begin
          chk("hcount", hcount, e.h);        chk("vcount", vcount, e.v);
          chk("hsync", hsync, e.hsy);        chk("vsync", vsync, e.vsy);
          chk("csync", csync, e.csy);        chk("hblank", hblank, e.hb);
          chk("vblank", vblank, e.vb);       chk("de", de, e.de);
          chk("line_start", line_start, e.ls);
          chk("frame_start", frame_start, e.fs);
          chk("act_x", act_x, e.ax);         chk("act_y", act_y, e.ay);
          chk("irq_pend", irq_pend, e.pend); chk("frame_cnt", frame_cnt, e.fc);
          chk("mode_active", mode_active, e.mode);
        end
      end
    end
  end

  // Reference model of the expected raster, advanced once per driven edge.
  typedef int slot_t [10];
  slot_t    m_bank [NM];
  slot_t    m_sh;
  int       m_h, m_v, m_mode, m_fc, m_ax, m_ay;
  bit       m_hs, m_vs, m_hb, m_vb, m_de, m_ls, m_fs;
  bit [1:0] m_pend;
  int       DEF [10] = '{448, 11, 43, 88, 448, 320, 8, 11, 32, 320};

  function automatic int fmask(input int a);
    return (a < 5) ? ((1 << HW) - 1) : ((1 << VW) - 1);
  endfunction

  function automatic bit win(input int p, input int b, input int e);
    return (p >= b) && (p < e);
  endfunction

  function automatic int clamp2(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic bit at_boundary();
    return (m_h >= clamp2(m_sh[0]) - 1) && (m_v >= clamp2(m_sh[5]) - 1);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NM; s++)
      for (int a = 0; a < 10; a++) m_bank[s][a] = DEF[a] & fmask(a);
    m_sh = m_bank[0];
    m_h = 0; m_v = 0; m_mode = 0; m_fc = 0; m_ax = 0; m_ay = 0;
    m_hs = 0; m_vs = 0; m_hb = 1; m_vb = 1; m_de = 0; m_ls = 0; m_fs = 0; m_pend = '0;
  endtask

  task automatic model_step(input bit pce);
    slot_t nb [NM];
    bit    ls, fs;
    exp_t  e;
    nb = m_bank;
    if (cfg_we && cfg_addr < 10) nb[cfg_mode][cfg_addr] = int'(cfg_wdata) & fmask(int'(cfg_addr));
    ls = 0; fs = 0;
    if (pce) begin
      if (m_h >= clamp2(m_sh[0]) - 1) begin
        m_h = 0; ls = 1;
        if (m_v >= clamp2(m_sh[5]) - 1) begin m_v = 0; fs = 1; end
        else m_v++;
      end else m_h++;
    end
    if (fs) begin
      m_sh = nb[mode_sel]; m_mode = int'(mode_sel); m_fc = (m_fc + 1) % 256;
    end
    m_bank = nb;
    if (pce) begin
      m_hs = win(m_h, m_sh[1], m_sh[2]);  m_vs = win(m_v, m_sh[6], m_sh[7]);
      m_hb = !win(m_h, m_sh[3], m_sh[4]); m_vb = !win(m_v, m_sh[8], m_sh[9]);
      m_de = !m_hb && !m_vb;
      m_ax = m_de ? m_h - m_sh[3] : 0;
      m_ay = m_de ? m_v - m_sh[8] : 0;
    end
    for (int i = 0; i < NI; i++) begin
      bit set;
      set = pce && irq_en[i] && (m_h == int'(irq_col[i*HW +: HW])) && (m_v == int'(irq_line[i*VW +: VW]));
      m_pend[i] = set | (m_pend[i] & ~irq_ack[i]);
    end
    m_ls = ls; m_fs = fs;
    e = '{cyc: cyc + 1, h: m_h, v: m_v, hsy: sync_pol ^ m_hs, vsy: sync_pol ^ m_vs,
          csy: !(m_hs ^ m_vs), hb: m_hb, vb: m_vb, de: m_de, ls: ls, fs: fs,
          ax: m_ax, ay: m_ay, pend: int'(m_pend), fc: m_fc, mode: m_mode};
    q.push_back(e);
  endtask

  task automatic step(input bit pce);
    pix_ce = pce;
    model_step(pce);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int every);
    for (int i = 0; i < n; i++) step((i % every) == 0);
  endtask

  task automatic cfg_write(input int m, input int a, input int d);
    cfg_we = 1'b1; cfg_mode = 2'(m); cfg_addr = 4'(a); cfg_wdata = 10'(d);
    step(1'b1);
    cfg_we = 1'b0;
  endtask

  // Hand-written reset state: counters 0, syncs idle, blanking on, strobes low.
  task automatic reset_hold(input int n);
    exp_t e;
    rst_n = 1'b0; pix_ce = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = '{cyc: cyc + 1, h: 0, v: 0, hsy: sync_pol, vsy: sync_pol, csy: 1, hb: 1, vb: 1,
            de: 0, ls: 0, fs: 0, ax: 0, ay: 0, pend: 0, fc: 0, mode: 0};
      q.push_back(e);
      @(negedge clk);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    @(negedge clk);
    reset_hold(3);

    // Default timing, continuous pixel enable, then one enable in three.
    run(900, 1);
    sync_pol = 1'b1;
    run(1350, 3);

    // Held reset mid-line, then a reset pulse between edges at hcount 200.
    for (int g = 0; g < 1000 && m_h != 200; g++) step(1'b1);
    reset_hold(2);
    for (int g = 0; g < 1000 && m_h != 200; g++) step(1'b1);
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_reset();
    step(1'b1);
    sync_pol = 1'b0;

    // Interrupts plus a 10x5 mode in slot 1 selected mid-frame.
    irq_col = {10'd100, 10'd20}; irq_line = {8'd2, 8'd40}; irq_en = 2'b11;
    cfg_write(1, 0, 10); cfg_write(1, 1, 2); cfg_write(1, 2, 4); cfg_write(1, 3, 1);
    cfg_write(1, 4, 8);  cfg_write(1, 5, 5); cfg_write(1, 6, 1); cfg_write(1, 7, 2);
    cfg_write(1, 8, 1);  cfg_write(1, 9, 4);
    for (int g = 0; g < 30000; g++) begin
      irq_ack[0] = (m_v == 40) && (m_h == 19 || m_h == 20);
      if (m_v == 10) irq_en[1] = 1'b0;
      if (m_v == 50) mode_sel = 2'd1;
      step(1'b1);
      if (m_fs) break;
    end
    irq_ack = '0;
    run(120, 1);

    // Empty hsync window, ignored address, and hperiod=1 written on the boundary edge.
    cfg_write(1, 1, 5); cfg_write(1, 2, 5); cfg_write(1, 13, 0);
    for (int g = 0; g < 200 && !at_boundary(); g++) step(1'b1);
    cfg_we = 1'b1; cfg_mode = 2'd1; cfg_addr = 4'd0; cfg_wdata = 10'd1;
    step(1'b1);
    cfg_we = 1'b0;
    run(40, 1);

    @(posedge clk); @(posedge clk); #2;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the video pipeline. It replaces fixed 50/60 Hz sync constants with a bank of runtime-programmable timing modes. It produces the pixel/line counters, syncs, blanking, display enable, active-area coordinates and per-channel raster interrupts consumed by the renderer, the DRAM fetch sequencer and the CPU interrupt controller. Every timing change applies only at a frame boundary, so the raster never tears mid-frame.

## Interface
Parameters:
- `HW`, 10: horizontal counter width.
- `VW`, 10: vertical counter width.
- `NMODES`, 4: number of timing-mode slots. `MW = $clog2(NMODES)`, minimum 1.
- `NIRQ`, 2: number of raster-interrupt compare channels.

Ports:
- `clk` in 1: system clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `pix_ce` in 1: pixel enable. Counters advance once per cycle in which it is high.
- `mode_sel` in MW: requested mode.
- `sync_pol` in 1: inverts `hsync`/`vsync` when high.
- `cfg_we` in 1, `cfg_mode` in MW, `cfg_addr` in 4, `cfg_wdata` in max(HW,VW): config register write port.
- `irq_line` in NIRQ*VW, `irq_col` in NIRQ*HW, `irq_en` in NIRQ, `irq_ack` in NIRQ: interrupt compare values, enables and acknowledges.
- `hcount` out HW, `vcount` out VW: raster position.
- `hsync`, `vsync`, `csync`, `hblank`, `vblank`, `de` out 1 each: sync, blanking and display-enable outputs.
- `line_start`, `frame_start` out 1 each: single-cycle strobes.
- `act_x` out HW, `act_y` out VW: coordinates inside the active area. Value is 0 outside it.
- `irq_pend` out NIRQ: sticky interrupt-pending flags.
- `frame_cnt` out 8: frame counter. Bit 4 is the FLASH phase.
- `mode_active` out MW: the mode currently in effect.

## Operation
- Each mode slot holds ten registers, addressed by `cfg_addr`:
  - 0 `hperiod`, 1 `hs_beg`, 2 `hs_end`, 3 `ha_beg`, 4 `ha_end`
  - 5 `vperiod`, 6 `vs_beg`, 7 `vs_end`, 8 `va_beg`, 9 `va_end`
- Writes to addresses 10–15 are ignored. Each value is truncated to the target register's width.
- Reset value of every slot: 448, 11, 43, 88, 448, 320, 8, 11, 32, 320.
- Shadow set: when `frame_start` fires, the registers of the slot selected by `mode_sel` are copied into the shadow set, and `mode_active` is updated. Counters and decode use only the shadow set.
- A write to the active slot takes effect at the next frame boundary.
- A write and a shadow copy of the same register in the same cycle: the shadow takes the new value.
- Horizontal counter: on `pix_ce`, `hcount` becomes 0 if `hcount >= hperiod-1`, otherwise it increments. The `>=` compare keeps the counter in range if the period shrinks.
- Vertical counter: `vcount` steps the same way against `vperiod`, only on the wrap of `hcount`.
- Period clamp: `hperiod` and `vperiod` values below 2 are treated as 2.
- Windows are half-open [beg,end):
  - `hs = hs_beg ≤ hcount < hs_end`; `vs` likewise.
  - `hblank = !(ha_beg ≤ hcount < ha_end)`; `vblank` likewise.
  - `de = !hblank && !vblank`.
  - If beg ≥ end, the window is empty.
- `hsync = sync_pol ^ hs`, `vsync = sync_pol ^ vs`, `csync = ~(hs ^ vs)`.
- `act_x = hcount - ha_beg` and `act_y = vcount - va_beg` when `de`, else 0.
- Interrupt channel i sets `irq_pend[i]` when `pix_ce && irq_en[i] && hcount == irq_col[i] && vcount == irq_line[i]`. An `irq_ack[i]` pulse clears it.
- If set and ack occur in the same cycle, set wins.
- Clearing `irq_en[i]` does not clear a pending flag.
- `frame_cnt` increments on `frame_start` and wraps at 255.

## Timing
- All outputs are registered.
- `hcount`/`vcount` update on the `clk` edge where `pix_ce` = 1.
- All decoded outputs reflect the new counter values on that same edge, with zero skew between counters and decode.
- `line_start` is high for exactly one cycle: the `pix_ce` cycle in which `hcount` becomes 0.
- `frame_start` is `line_start` qualified with `vcount` becoming 0.
- Shadow load and `mode_active` update happen on the same edge as `frame_start`. The first pixel of the new frame already uses the new mode.
- While `pix_ce` = 0, all outputs hold and the strobes are low.
- Reset (asynchronous, any time, including mid-line):
  - counters = 0, `frame_cnt` = 0, `irq_pend` = 0, `mode_active` = 0, shadow = slot-0 defaults, config = defaults.
  - `hs`/`vs` decode to 0, so `hsync = vsync = sync_pol`, `csync` = 1.
  - `hblank = vblank` = 1, `de` = 0, strobes = 0.
- First `pix_ce` after reset: `hcount` = 1. No `line_start` occurs until wrap.

## Structure
- Package `video_timing_pkg` holds:
  - register-address localparams `VT_HPERIOD`..`VT_VA_END`
  - reset-default constants
  - a packed struct `vt_mode_t` for one slot
- Sub-module `video_timing_regs` contains the config bank, write port and shadow-copy logic, and outputs `vt_mode_t`.
- The top level contains the counters, decode and interrupts.

## Test plan
- Reset defaults, `pix_ce` = 1 continuously → `line_start` every 448 cycles, `frame_start` every 143360 cycles. `hsync` active for `hcount` 11..42; `de` high for `hcount` 88..447 with `vcount` 32..319.
- `pix_ce` high one cycle in three → identical sequence, 3× stretched. All outputs frozen on idle cycles.
- Program slot 1 with periods 10/5, change `mode_sel` to 1 mid-frame → old timing continues until `frame_start`, then the 10×5 raster starts. `mode_active` = 1 on the same edge.
- `irq_col` = 20, `irq_line` = 40, enabled → `irq_pend[0]` rises at (20,40). Ack in that same cycle leaves it set; ack one cycle later clears it.
- Assert `rst_n` = 0 at `hcount` 200 → immediate outputs per the reset list. Timing restarts from 0/0 after release.
- Write `hperiod` = 1, with `hs_beg` = `hs_end` = 5 → raster of period 2, `hsync` constantly inactive.
